// File: rtl/mult_seq_if.sv
// Request/response and shared-ALU signals for the sequential multiplier.
interface mult_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] product;
    logic [2:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        alu_zero;

    modport slave (
        input  start, a, b, alu_out, alu_zero,
        output ready, done, product, alu_op, alu_in1, alu_in2
    );
    modport master (
        output start, a, b, alu_out, alu_zero,
        input  ready, done, product, alu_op, alu_in1, alu_in2
    );
endinterface

// File: rtl/mult_seq.sv
// Shift-add 32x32 multiplier (low 32 bits) that borrows an external ALU for add and shift.
// Optional macro MULT_SEQ_EARLY_EXIT_EN stops iterating once no multiplier bits remain.
module mult_seq (
    input  logic         clk,
    input  logic         rst,
    mult_seq_if.slave    io
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADD   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;
    logic        last_iter;

    logic [2:0]  alu_op;
    logic [31:0] alu_in1, alu_in2;

    // The zero flag is part of the shared ALU bundle but not needed here.
    logic unused_alu_zero;
    assign unused_alu_zero = io.alu_zero;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    assign last_iter = (cnt_q == 6'd31) || ((mplier_q >> 1) == 32'd0);
`else
    assign last_iter = (cnt_q == 6'd31);
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_op    = 3'b000;
        alu_in1   = 32'd0;
        alu_in2   = 32'd0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    acc_d    = 32'd0;
                    mcand_d  = io.a;
                    mplier_d = io.b;
                    cnt_d    = 6'd0;
                    state_d  = ADD;
                end
            end
            ADD: begin
                alu_op  = 3'b010;
                alu_in1 = acc_q;
                alu_in2 = mplier_q[0] ? mcand_q : 32'd0;
                acc_d   = io.alu_out;
                state_d = SHIFT;
            end
            SHIFT: begin
                alu_op   = 3'b100;
                alu_in1  = 32'd1;
                alu_in2  = mcand_q;
                mcand_d  = io.alu_out;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (last_iter) begin
                    state_d   = DONE;
                    product_d = acc_q;
                end else begin
                    state_d = ADD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            cnt_q     <= 6'd0;
            product_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign io.ready   = (state_q == IDLE);
    assign io.done    = (state_q == DONE);
    assign io.product = product_q;
    assign io.alu_op  = alu_op;
    assign io.alu_in1 = alu_in1;
    assign io.alu_in2 = alu_in2;
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: transaction-level model plus directed vectors.
module tb_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_seq_if bus();
    mult_seq dut (.clk(clk), .rst(rst), .io(bus.slave));

    always #5 clk = ~clk;

    // Shared ALU model
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_out = bus.alu_in1 & bus.alu_in2;
            3'b001:  bus.alu_out = bus.alu_in1 | bus.alu_in2;
            3'b010:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
            3'b100:  bus.alu_out = bus.alu_in2 << bus.alu_in1[4:0];
            3'b110:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
            3'b111:  bus.alu_out = {31'd0, $signed(bus.alu_in1) < $signed(bus.alu_in2)};
            default: bus.alu_out = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_out == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Iterations until DONE for a given multiplier
    function automatic int iters(input logic [31:0] b);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    // Transaction-level model: accept when idle, finish 2*iters edges later
    int          edge_cnt = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_end = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (m_done) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_pend <= bus.a * bus.b;
                    m_end  <= edge_cnt + 1 + 2 * iters(bus.b);
                end
            end else if (edge_cnt + 1 == m_end) begin
                m_prod <= m_pend;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", {31'd0, bus.ready}, {31'd0, !m_busy});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("product", bus.product, m_prod);
        end
    end

    // Run one multiply; optional stray start pulse and optional mid-op reset
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_prod, input int exp_lat,
                          input int pulse_at, input int rst_at, input string name);
        int n = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        forever begin
            @(negedge clk);
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk({name, "_rst_ready"}, {31'd0, bus.ready}, 32'd1);
                chk({name, "_rst_product"}, bus.product, 32'd0);
                @(negedge clk);
                chk({name, "_rst_nodone"}, {31'd0, bus.done}, 32'd0);
                rst = 1'b0;
                return;
            end
            if (bus.done) break;
            if (n == pulse_at) begin
                bus.a = 32'd7; bus.b = 32'd7; bus.start = 1'b1;
            end else if (n == pulse_at + 1) begin
                bus.start = 1'b0;
            end
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
                return;
            end
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_product"}, bus.product, exp_prod);
        @(negedge clk);
        chk({name, "_ready_after"}, {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_product", bus.product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef MULT_SEQ_EARLY_EXIT_EN
        run_op(32'd3, 32'd5, 32'd15, 6, -10, -10, "mul3x5");
        run_op(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4, -10, -10, "wrap");
        run_op(32'h12345678, 32'd0, 32'd0, 2, -10, -10, "bzero");
        run_op(32'd3, 32'd5, 32'd15, 6, 3, -10, "ignore_start");
        run_op(32'h0001_0001, 32'h8000_0003, 32'h8003_0003, 64, -10, -10, "topbit");
        run_op(32'd3, 32'hFFFFFFFF, 32'd0, 64, -10, 20, "abort");
        run_op(32'd7, 32'd7, 32'd49, 6, -10, -10, "after_rst");
`else
        run_op(32'd3, 32'd5, 32'd15, 64, -10, -10, "mul3x5");
        run_op(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 64, -10, -10, "wrap");
        run_op(32'h12345678, 32'd0, 32'd0, 64, -10, -10, "bzero");
        run_op(32'd3, 32'd5, 32'd15, 64, 10, -10, "ignore_start");
        run_op(32'h0001_0001, 32'h8000_0003, 32'h8003_0003, 64, -10, -10, "topbit");
        run_op(32'd3, 32'hFFFFFFFF, 32'd0, 64, -10, 20, "abort");
        run_op(32'd7, 32'd7, 32'd49, 64, -10, -10, "after_rst");
`endif
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 64, -10, -10, "allones");
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
